avalon_pio_bank: RTL

- Parametrised multi-channel Avalon-MM output register bank; successor to the single 32-bit PIO registers that drive raymarcher uniforms (camera position, direction and similar).
- Each channel has a CPU-writable shadow register and an active register driving the GPU.
- Shadows are copied to actives atomically on a commit, either immediately or at the next frame_sync rising edge, so all channels change together between frames.

---
 rtl/avalon_pio_bank_pkg.sv | 22 ++
 rtl/avalon_pio_bank_if.sv | 23 ++
 rtl/avalon_pio_bank_commit_ctrl.sv | 46 ++++
 rtl/avalon_pio_bank.sv | 98 +++++++++
 4 files changed

// File: rtl/avalon_pio_bank_pkg.sv
// Shared constants and helpers for the PIO output bank: CTRL/STATUS bit
// positions, address offsets and the commit request passed to the controller.
package pio_bank_pkg;
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_SYNC_BIT   = 1;
    localparam int STAT_PEND_BIT   = 0;
    localparam int STAT_SEEN_BIT   = 1;

    typedef struct packed {
        logic wr;      // qualified CTRL write
        logic commit;  // COMMIT bit of that write
        logic sync;    // SYNC_MODE bit of that write
    } ctrl_req_t;

    function automatic int ctrl_addr(input int num_ch);
        return num_ch;
    endfunction

    function automatic int stat_addr(input int num_ch);
        return num_ch + 1;
    endfunction
endpackage

// File: rtl/avalon_pio_bank_if.sv
// Avalon-MM slave bus of the PIO bank. PIO_BYTEENABLE_EN adds the byteenable lane.
interface avalon_pio_bank_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
`ifdef PIO_BYTEENABLE_EN
    logic [3:0]        byteenable;

    modport master (output address, chipselect, write_n, writedata, byteenable,
                    input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata, byteenable,
                    output readdata);
`else
    modport master (output address, chipselect, write_n, writedata,
                    input  readdata);
    modport slave  (input  address, chipselect, write_n, writedata,
                    output readdata);
`endif
endinterface

// File: rtl/avalon_pio_bank_commit_ctrl.sv
// Commit sequencing: frame_sync edge detect, armed-commit flag, load strobe
// for the active registers and the registered one-cycle update pulse.
module pio_commit_ctrl
    import pio_bank_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_frame_sync,
    input  ctrl_req_t i_req,
    output logic      o_load,
    output logic      o_update,
    output logic      o_pending,
    output logic      o_sync_mode
);
    logic r_fs_prev, r_pending, r_sync, r_update;
    logic w_rise, w_sync_nxt, w_commit, w_load;

    // The mode carried by a CTRL write governs that same write's commit.
    assign w_sync_nxt = i_req.wr ? i_req.sync : r_sync;
    assign w_commit   = i_req.wr & i_req.commit;
    assign w_rise     = i_frame_sync & ~r_fs_prev;
    assign w_load     = w_sync_nxt ? (r_pending & w_rise) : w_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fs_prev <= 1'b0;
            r_pending <= 1'b0;
            r_sync    <= 1'b0;
            r_update  <= 1'b0;
        end else begin
            r_fs_prev <= i_frame_sync;
            r_sync    <= w_sync_nxt;
            r_update  <= w_load;
            // Leaving sync mode discards an armed commit; re-arming while armed is a no-op.
            if (!w_sync_nxt || w_load)
                r_pending <= 1'b0;
            else if (w_commit)
                r_pending <= 1'b1;
        end
    end

    assign o_load      = w_load;
    assign o_update    = r_update;
    assign o_pending   = r_pending;
    assign o_sync_mode = r_sync;
endmodule

// File: rtl/avalon_pio_bank.sv
// Multi-channel Avalon-MM shadow/active output register bank with atomic commit.
// Optional macro PIO_BYTEENABLE_EN enables byte-lane writes via the bus byteenable.
module avalon_pio_bank
    import pio_bank_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    avalon_pio_bank_if.slave         bus,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] out_port,
    output logic                     update,
    output logic                     pending
);
    if (NUM_CH < 1 || NUM_CH > 16 || DATA_W < 8 || DATA_W > 32 ||
        (2**ADDR_W) < NUM_CH + 2) begin : g_bad_cfg
        $error("avalon_pio_bank: unsupported NUM_CH/DATA_W/ADDR_W combination");
    end

    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(ctrl_addr(NUM_CH));
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(stat_addr(NUM_CH));

    logic [NUM_CH-1:0][DATA_W-1:0] r_shadow, r_active;
    logic                          r_seen;
    logic                          w_wr, w_stat_rd, w_ctrl_en, w_load, w_sync;
    logic [31:0]                   w_mask, w_rdata;
    ctrl_req_t                     w_req;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_stat_rd = bus.chipselect &  bus.write_n & (bus.address == A_STAT);

`ifdef PIO_BYTEENABLE_EN
    assign w_mask    = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                        {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};
    assign w_ctrl_en = bus.byteenable[0];
`else
    assign w_mask    = '1;
    assign w_ctrl_en = 1'b1;
`endif

    assign w_req.wr     = w_wr & w_ctrl_en & (bus.address == A_CTRL);
    assign w_req.commit = bus.writedata[CTRL_COMMIT_BIT];
    assign w_req.sync   = bus.writedata[CTRL_SYNC_BIT];

    pio_commit_ctrl u_commit (
        .clk         (clk),
        .rst         (reset),
        .i_frame_sync(frame_sync),
        .i_req       (w_req),
        .o_load      (w_load),
        .o_update    (update),
        .o_pending   (pending),
        .o_sync_mode (w_sync)
    );

    // Actives sample the pre-write shadows, so a same-cycle shadow write waits for the next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= {NUM_CH{RESET_VAL}};
            r_active <= {NUM_CH{RESET_VAL}};
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (w_wr && bus.address == ADDR_W'(i))
                    r_shadow[i] <= (r_shadow[i] & ~w_mask[DATA_W-1:0]) |
                                   (bus.writedata[DATA_W-1:0] & w_mask[DATA_W-1:0]);
            if (w_load)
                r_active <= r_shadow;
        end
    end

    // A pulse coinciding with a STATUS read must not be lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_seen <= 1'b0;
        else if (update)    r_seen <= 1'b1;
        else if (w_stat_rd) r_seen <= 1'b0;
    end

    always_comb begin
        w_rdata = '0;
        if (bus.address == A_CTRL) begin
            w_rdata[CTRL_SYNC_BIT] = w_sync;
        end else if (bus.address == A_STAT) begin
            w_rdata[STAT_PEND_BIT] = pending;
            w_rdata[STAT_SEEN_BIT] = r_seen;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (bus.address == ADDR_W'(i))
                    w_rdata[DATA_W-1:0] = r_shadow[i];
        end
    end

    assign bus.readdata = w_rdata;
    assign out_port     = r_active;
endmodule
